// File: rtl/wb_slave_mux_n.sv
// -----------------------------------------------------------------------------
// wb_slave_mux_n
//
// Purpose
//   Connects one Wishbone master (the Caravel management SoC) to NUM_SLAVES
//   Wishbone slaves through a registered request/response FSM.
//   - An address outside the user window, or with a slave index >= NUM_SLAVES,
//     gets an immediate error response.
//   - A slave that never acks is cut off after TIMEOUT_CYC busy cycles with an
//     error response.
//   The SoC therefore never stalls on an unmapped or hung slave.
//
// Handshake
//   Master side: a request is taken when m_wb_cyc_i & m_wb_stb_i are sampled
//   high in IDLE. Exactly one m_wb_ack_o pulse follows, with m_wb_err_o in the
//   same cycle on a decode miss or timeout. m_wb_dat_o is valid only in the ack
//   cycle and holds its value otherwise. Dropping m_wb_cyc_i while the slave is
//   busy abandons the transfer, and no ack follows.
//   Slave side: the s_wb_cyc_o/s_wb_stb_o bit of the selected slave stays high,
//   with stable we/adr/dat/sel, until that slave's s_wb_ack_i is sampled high.
//   Acks from any other slave, or any ack outside BUSY, are ignored.
//
// Ports
//   wb_clk_i, wb_rst_n_i   clock; synchronous active-low reset
//   m_wb_*                 master-facing port (cyc/stb/we/adr/dat/sel in;
//                          dat/ack/err out)
//   s_wb_cyc_o/stb_o       one-hot per-slave cycle/strobe
//   s_wb_we/adr/dat/sel_o  shared registered request fields
//   s_wb_dat_i             packed slave read data; slave k occupies
//                          [k*DATA_WD +: DATA_WD]
//   s_wb_ack_i             per-slave acks
//
// Optional feature (macro WB_MUX_ERR_LOG_EN)
//   err_addr_o             address of the most recent errored transfer
//   err_cnt_o              errored-transfer count, saturating at 8'hFF
//
// Debug: the FSM state is held in state_q (type state_e).
// -----------------------------------------------------------------------------
module wb_slave_mux_n #(
  parameter int unsigned          NUM_SLAVES  = 4,
  parameter int unsigned          ADDR_WD     = 32,
  parameter int unsigned          DATA_WD     = 32,
  parameter logic [ADDR_WD-1:0]   BASE_ADDR   = ADDR_WD'(32'h3000_0000),
  parameter logic [ADDR_WD-1:0]   BASE_MASK   = ADDR_WD'(32'hFFF0_0000),
  parameter int unsigned          SEL_LSB     = 16,
  parameter int unsigned          TIMEOUT_CYC = 255,
  parameter logic [DATA_WD-1:0]   ERR_DATA    = DATA_WD'(32'hDEAD_BEEF)
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_n_i,
  input  logic                          m_wb_cyc_i,
  input  logic                          m_wb_stb_i,
  input  logic                          m_wb_we_i,
  input  logic [ADDR_WD-1:0]            m_wb_adr_i,
  input  logic [DATA_WD-1:0]            m_wb_dat_i,
  input  logic [DATA_WD/8-1:0]          m_wb_sel_i,
  output logic [DATA_WD-1:0]            m_wb_dat_o,
  output logic                          m_wb_ack_o,
  output logic                          m_wb_err_o,
  output logic [NUM_SLAVES-1:0]         s_wb_cyc_o,
  output logic [NUM_SLAVES-1:0]         s_wb_stb_o,
  output logic                          s_wb_we_o,
  output logic [ADDR_WD-1:0]            s_wb_adr_o,
  output logic [DATA_WD-1:0]            s_wb_dat_o,
  output logic [DATA_WD/8-1:0]          s_wb_sel_o,
  input  logic [NUM_SLAVES*DATA_WD-1:0] s_wb_dat_i,
  input  logic [NUM_SLAVES-1:0]         s_wb_ack_i
`ifdef WB_MUX_ERR_LOG_EN
  ,
  output logic [ADDR_WD-1:0]            err_addr_o,
  output logic [7:0]                    err_cnt_o
`endif
);

  localparam int unsigned SELW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CNTW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned SW   = DATA_WD / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   we_q, we_d;
  logic [ADDR_WD-1:0]     adr_q, adr_d;
  logic [DATA_WD-1:0]     wdat_q, wdat_d;
  logic [SW-1:0]          sel_q, sel_d;
  logic [SELW-1:0]        idx_q, idx_d;
  logic [NUM_SLAVES-1:0]  cyc_q, cyc_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [DATA_WD-1:0]     rdat_q, rdat_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;

  logic                   req;
  logic [SELW-1:0]        req_idx;
  logic                   win_hit;
  logic                   idx_ok;
  logic [NUM_SLAVES-1:0]  req_onehot;
  logic                   sel_ack;
  logic [DATA_WD-1:0]     sel_rdat;
  logic [CNTW-1:0]        cnt_inc;

  assign req        = m_wb_cyc_i & m_wb_stb_i;
  assign req_idx    = m_wb_adr_i[SEL_LSB +: SELW];
  assign win_hit    = ((m_wb_adr_i & BASE_MASK) == BASE_ADDR);
  assign req_onehot = NUM_SLAVES'(1) << req_idx;
  // cyc_q is one-hot (or zero), so masking the acks with it picks only the
  // selected slave's ack.
  assign sel_ack    = |(s_wb_ack_i & cyc_q);
  assign cnt_inc    = cnt_q + CNTW'(1);

  // When NUM_SLAVES is a power of two, every index value maps to a slave.
  if ((1 << SELW) == NUM_SLAVES) begin : g_idx_full
    assign idx_ok = 1'b1;
  end else begin : g_idx_part
    assign idx_ok = (32'(req_idx) < NUM_SLAVES);
  end

  always_comb begin
    sel_rdat = '0;
    for (int k = 0; k < int'(NUM_SLAVES); k++) begin
      if (idx_q == SELW'(k)) begin
        sel_rdat = s_wb_dat_i[k*DATA_WD +: DATA_WD];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    cyc_d   = cyc_q;
    cnt_d   = cnt_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d   = m_wb_we_i;
          adr_d  = m_wb_adr_i;
          wdat_d = m_wb_dat_i;
          sel_d  = m_wb_sel_i;
          idx_d  = req_idx;
          cnt_d  = '0;
          if (win_hit && idx_ok) begin
            cyc_d   = req_onehot;
            state_d = ST_BUSY;
          end else begin
            rdat_d  = ERR_DATA;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_BUSY: begin
        // Abort has priority over both a slave ack and the timeout.
        if (!m_wb_cyc_i) begin
          cyc_d   = '0;
          state_d = ST_IDLE;
        end else if (sel_ack) begin
          cyc_d   = '0;
          rdat_d  = we_q ? '0 : sel_rdat;
          ack_d   = 1'b1;
          state_d = ST_RESP;
        end else if (cnt_inc == CNTW'(TIMEOUT_CYC)) begin
          cyc_d   = '0;
          rdat_d  = ERR_DATA;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        cyc_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
      cyc_q   <= '0;
      cnt_q   <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign m_wb_dat_o = rdat_q;
  assign m_wb_ack_o = ack_q;
  assign m_wb_err_o = err_q;
  assign s_wb_cyc_o = cyc_q;
  assign s_wb_stb_o = cyc_q;
  assign s_wb_we_o  = we_q;
  assign s_wb_adr_o = adr_q;
  assign s_wb_dat_o = wdat_q;
  assign s_wb_sel_o = sel_q;

`ifdef WB_MUX_ERR_LOG_EN
  logic [ADDR_WD-1:0] err_addr_q;
  logic [7:0]         err_cnt_q;

  // The log changes on the same edge that raises the error ack, so it is
  // already current during the RESP cycle.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else if (ack_d && err_d) begin
      err_addr_q <= adr_d;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign err_addr_o = err_addr_q;
  assign err_cnt_o  = err_cnt_q;
`endif

endmodule

// File: tb/tb_wb_slave_mux_n.sv
module tb_wb_slave_mux_n;

  localparam int NS      = 4;
  localparam int DW      = 32;
  localparam int SELW    = 2;
  localparam int SEL_LSB = 16;
  localparam int T       = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] MASK = 32'hFFF0_0000;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic m_cyc, m_stb, m_we;
  logic [31:0] m_adr, m_dat;
  logic [3:0]  m_sel;
  logic [31:0] m_wb_dat_o;
  logic        m_wb_ack_o, m_wb_err_o;
  logic [NS-1:0] s_wb_cyc_o, s_wb_stb_o;
  logic        s_wb_we_o;
  logic [31:0] s_wb_adr_o, s_wb_dat_o;
  logic [3:0]  s_wb_sel_o;
  logic [NS*DW-1:0] s_dat;
  logic [NS-1:0]    s_ack;
`ifdef WB_MUX_ERR_LOG_EN
  logic [31:0] err_addr_o;
  logic [7:0]  err_cnt_o;
`endif

  always #5 clk = ~clk;

  wb_slave_mux_n #(
    .NUM_SLAVES (NS),
    .ADDR_WD    (32),
    .DATA_WD    (DW),
    .BASE_ADDR  (BASE),
    .BASE_MASK  (MASK),
    .SEL_LSB    (SEL_LSB),
    .TIMEOUT_CYC(T),
    .ERR_DATA   (ERRD)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .m_wb_cyc_i (m_cyc),
    .m_wb_stb_i (m_stb),
    .m_wb_we_i  (m_we),
    .m_wb_adr_i (m_adr),
    .m_wb_dat_i (m_dat),
    .m_wb_sel_i (m_sel),
    .m_wb_dat_o (m_wb_dat_o),
    .m_wb_ack_o (m_wb_ack_o),
    .m_wb_err_o (m_wb_err_o),
    .s_wb_cyc_o (s_wb_cyc_o),
    .s_wb_stb_o (s_wb_stb_o),
    .s_wb_we_o  (s_wb_we_o),
    .s_wb_adr_o (s_wb_adr_o),
    .s_wb_dat_o (s_wb_dat_o),
    .s_wb_sel_o (s_wb_sel_o),
    .s_wb_dat_i (s_dat),
    .s_wb_ack_i (s_ack)
`ifdef WB_MUX_ERR_LOG_EN
    ,
    .err_addr_o (err_addr_o),
    .err_cnt_o  (err_cnt_o)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];
  logic [31:0] last_dat     = '0;
  int          err_total    = 0;
  logic [31:0] last_err_adr = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Address decode straight from the window/index rule.
  function automatic bit model_hit(input logic [31:0] adr);
    logic [SELW-1:0] f;
    f = adr[SEL_LSB +: SELW];
    return ((adr & MASK) == BASE) && (int'(f) < NS);
  endfunction

  function automatic logic [31:0] rand_hit_adr();
    return BASE | ($urandom & 32'h000F_FFFF);
  endfunction

  function automatic logic [31:0] rand_miss_adr();
    logic [31:0] a;
    a = $urandom;
    while (model_hit(a)) a = $urandom;
    return a;
  endfunction

  // ---------------- driver tasks ----------------
  // ack_at: number of strobe cycles the slave sees before it acks
  // (1 = zero-wait); 0 = the slave never acks. late: the selected slave
  // also acks in the response cycle.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         input logic [3:0] sel, input logic [31:0] rdat,
                         input int ack_at, input bit late);
    bit hit, err;
    int idx, resp_c;
    logic [3:0] oh, noise;
    logic [31:0] exp_dat;
    logic [NS*DW-1:0] v;
    hit = model_hit(adr);
    idx = int'(adr[SEL_LSB +: SELW]);
    oh  = hit ? (4'b0001 << idx) : 4'b0000;
    if (!hit)             begin resp_c = 0;      err = 1'b1; exp_dat = ERRD; end
    else if (ack_at == 0) begin resp_c = T;      err = 1'b1; exp_dat = ERRD; end
    else                  begin resp_c = ack_at; err = 1'b0; exp_dat = we ? 32'h0 : rdat; end
    exp_q.push_back(exp_dat);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_adr = adr; m_dat = wdat; m_sel = sel;
    for (int c = 0; c <= resp_c + 1; c++) begin
      @(negedge clk);
      check_eq("ack", 64'(m_wb_ack_o), 64'(c == resp_c));
      check_eq("err", 64'(m_wb_err_o), 64'((c == resp_c) && err));
      check_eq("stb", 64'(s_wb_stb_o), (c < resp_c) ? 64'(oh) : 64'(0));
      check_eq("cyc", 64'(s_wb_cyc_o), (c < resp_c) ? 64'(oh) : 64'(0));
      if (c == resp_c) begin
        if (exp_q.size() == 0) check_eq("rdat_queue_empty", 64'(1), 64'(0));
        else begin
          last_dat = exp_q.pop_front();
          check_eq("rdat", 64'(m_wb_dat_o), 64'(last_dat));
        end
        if (err) begin err_total++; last_err_adr = adr; end
      end else begin
        check_eq("rdat_hold", 64'(m_wb_dat_o), 64'(last_dat));
      end
      if (hit && c < resp_c) begin
        check_eq("s_we",  64'(s_wb_we_o),  64'(we));
        check_eq("s_adr", 64'(s_wb_adr_o), 64'(adr));
        check_eq("s_dat", 64'(s_wb_dat_o), 64'(wdat));
        check_eq("s_sel", 64'(s_wb_sel_o), 64'(sel));
      end
      // slave side: noise acks from other slaves, selected ack only when due
      noise = 4'($urandom);
      s_ack = (c < resp_c) ? (noise & ~oh) : noise;
      if (hit && ack_at > 0 && c == ack_at - 1) s_ack = s_ack | oh;
      if (late && c == resp_c) s_ack = s_ack | oh;
      for (int k = 0; k < NS; k++) v[k*DW +: DW] = $urandom;
      if (hit) v[idx*DW +: DW] = rdat;
      s_dat = v;
      if (c == resp_c) begin m_cyc = 1'b0; m_stb = 1'b0; end
    end
    s_ack = '0;
  endtask

  // Master drops cyc in strobe cycle k; with_ack makes the slave ack then too.
  task automatic run_abort(input logic [31:0] adr, input int k, input bit with_ack);
    int idx;
    logic [3:0] oh;
    idx = int'(adr[SEL_LSB +: SELW]);
    oh  = 4'b0001 << idx;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'($urandom); m_adr = adr;
    m_dat = $urandom; m_sel = 4'($urandom);
    for (int c = 0; c <= k + 2; c++) begin
      @(negedge clk);
      check_eq("abort_ack", 64'(m_wb_ack_o), 64'(0));
      check_eq("abort_err", 64'(m_wb_err_o), 64'(0));
      check_eq("abort_stb", 64'(s_wb_stb_o), (c <= k) ? 64'(oh) : 64'(0));
      check_eq("abort_rdat_hold", 64'(m_wb_dat_o), 64'(last_dat));
      s_ack = 4'($urandom) & ~oh;
      if (c == k) begin
        m_cyc = 1'b0; m_stb = 1'b0;
        if (with_ack) s_ack = s_ack | oh;
      end
    end
    s_ack = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ack"},  64'(m_wb_ack_o), 64'(0));
    check_eq({tag, "_err"},  64'(m_wb_err_o), 64'(0));
    check_eq({tag, "_rdat"}, 64'(m_wb_dat_o), 64'(0));
    check_eq({tag, "_cyc"},  64'(s_wb_cyc_o), 64'(0));
    check_eq({tag, "_stb"},  64'(s_wb_stb_o), 64'(0));
    check_eq({tag, "_we"},   64'(s_wb_we_o),  64'(0));
    check_eq({tag, "_adr"},  64'(s_wb_adr_o), 64'(0));
    check_eq({tag, "_wdat"}, 64'(s_wb_dat_o), 64'(0));
    check_eq({tag, "_sel"},  64'(s_wb_sel_o), 64'(0));
`ifdef WB_MUX_ERR_LOG_EN
    check_eq({tag, "_err_cnt"},  64'(err_cnt_o),  64'(0));
    check_eq({tag, "_err_addr"}, 64'(err_addr_o), 64'(0));
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r;
    rst_n = 1'b0; m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    m_adr = '0; m_dat = '0; m_sel = '0; s_dat = '0; s_ack = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // zero-wait read from slave 1
    run_txn(1'b0, 32'h3001_0000, 32'h0, 4'hF, 32'h1234_5678, 1, 1'b0);
    // write to slave 0 with three wait cycles
    run_txn(1'b1, 32'h3000_0004, 32'hA5A5_A5A5, 4'b0011, 32'h0BAD_F00D, 4, 1'b0);
    // decode misses: outside the window
    run_txn(1'b0, 32'h2000_0000, 32'h0, 4'hF, 32'h0, 1, 1'b0);
    run_txn(1'b1, 32'h3010_0000, 32'h55AA_55AA, 4'hF, 32'h0, 1, 1'b0);
    // hung slave 2 times out; its late ack is ignored
    run_txn(1'b0, 32'h3002_0000, 32'h0, 4'hF, 32'h7777_7777, 0, 1'b1);
    // master drops cyc while slave 3 acks
    run_abort(32'h3003_0000, 2, 1'b1);
    // master drops cyc exactly when the timeout would fire
    run_abort(32'h3001_0000, T - 1, 1'b0);
    // a normal transfer right after an abort
    run_txn(1'b0, 32'h3003_0040, 32'h0, 4'hF, 32'hCAFE_0003, 2, 1'b0);

    // reset in the middle of a busy transfer
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_adr = 32'h3002_0010;
    m_dat = 32'h1357_9BDF; m_sel = 4'hF;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("mid_busy_reset");
    rst_n = 1'b1; m_cyc = 1'b0; m_stb = 1'b0;
    last_dat = '0; err_total = 0; last_err_adr = '0;

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2)
        run_txn(1'($urandom), rand_miss_adr(), $urandom, 4'($urandom), $urandom, 1, 1'b0);
      else if (r == 2)
        run_txn(1'($urandom), rand_hit_adr(), $urandom, 4'($urandom), $urandom, 0, 1'($urandom));
      else if (r == 3)
        run_abort(rand_hit_adr(), $urandom_range(0, T - 1), 1'($urandom));
      else
        run_txn(1'($urandom), rand_hit_adr(), $urandom, 4'($urandom), $urandom,
                $urandom_range(1, T - 1), 1'($urandom));
    end

`ifdef WB_MUX_ERR_LOG_EN
    for (int i = 0; i < 300; i++)
      run_txn(1'($urandom), rand_miss_adr(), $urandom, 4'($urandom), $urandom, 1, 1'b0);
    check_eq("err_cnt",  64'(err_cnt_o),  64'((err_total > 255) ? 255 : err_total));
    check_eq("err_addr", 64'(err_addr_o), 64'(last_err_adr));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
